// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and opcode constants for the ALU arbiter.
//   state_t : arbiter FSM states
//   owner_t : which requester owns the op currently on the ALU
//   op_t    : registered operation driven onto the ALU
package alu_arb_pkg;

    localparam logic [4:0] ZERO_OP     = 5'd0;
    localparam logic [4:0] ADD_OP      = 5'd1;
    localparam logic [4:0] SUB_OP1     = 5'd2;
    localparam logic [4:0] ADD_FLAG_OP = 5'd3;
    localparam logic [4:0] MUL_OP      = 5'd4;

    typedef enum logic [1:0] {IDLE, EXEC, MULW} state_t;
    typedef enum logic [1:0] {NONE, EX, AG} owner_t;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [31:0] op1;
        logic [31:0] op2;
        owner_t      owner;
        logic        set_flags;
    } op_t;

    localparam op_t OP_IDLE = '{opcode: ZERO_OP, op1: 32'd0, op2: 32'd0, owner: NONE, set_flags: 1'b0};

endpackage

// File: rtl/alu_arb_grant.sv
// alu_arb_grant: ready/grant logic with EX priority and an AG starvation guard.
//   clk, rst_n      : clock, async active-low reset
//   can_accept      : ALU can take a new op this cycle
//   flush           : EX kill; EX cannot be accepted while high
//   ex_req_valid    : EX request valid
//   ag_req_valid    : AG request valid
//   ex_req_ready    : EX accepted if valid
//   ag_req_ready    : AG accepted if valid
module alu_arb_grant #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic can_accept,
    input  logic flush,
    input  logic ex_req_valid,
    input  logic ag_req_valid,
    output logic ex_req_ready,
    output logic ag_req_ready
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          starve_hit;

    assign starve_hit   = (starve_cnt == CW'(STARVE_LIMIT));
    assign ex_req_ready = can_accept & ~flush & ~(ag_req_valid & starve_hit);
    assign ag_req_ready = can_accept & (~ex_req_valid | flush | starve_hit);

    // Counts cycles AG waits while valid; saturates at the limit so AG wins exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else
            starve_cnt <= (ag_req_valid & ~ag_req_ready) ? (starve_hit ? starve_cnt : starve_cnt + CW'(1)) : '0;
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between EX and AG and owns the APSR.
//   clk, rst_n                         : clock, async active-low reset
//   flush                              : kills an in-flight EX op
//   ex_req_* / ag_req_*                : request handshakes, opcode and operands
//   alu_opcode, alu_op1, alu_op2       : registered op driven to the ALU
//   alu_flag                           : APSR fed to the ALU
//   alu_result, alu_flag_q             : ALU outputs
//   ex_rsp_valid/ex_result             : EX response pulse and result
//   ag_rsp_valid/ag_result             : AG response pulse and result
//   apsr_flags                         : architectural NZCV
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int         MUL_CYCLES   = 4,
    parameter int         STARVE_LIMIT = 4,
    parameter logic [3:0] FLAG_RESET   = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        ex_req_valid,
    output logic        ex_req_ready,
    input  logic [4:0]  ex_opcode,
    input  logic [31:0] ex_op1,
    input  logic [31:0] ex_op2,
    input  logic        ex_set_flags,
    input  logic        ag_req_valid,
    output logic        ag_req_ready,
    input  logic [4:0]  ag_opcode,
    input  logic [31:0] ag_op1,
    input  logic [31:0] ag_op2,
    output logic [4:0]  alu_opcode,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [3:0]  alu_flag,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flag_q,
    output logic        ex_rsp_valid,
    output logic [31:0] ex_result,
    output logic        ag_rsp_valid,
    output logic [31:0] ag_result,
    output logic [3:0]  apsr_flags
);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    op_t        op, op_nx;
    logic       fin, can_accept, ex_hs, ag_hs, killed, is_mul, ex_done;
    logic [4:0] nx_opcode;

    assign fin        = (state == EXEC) | ((state == MULW) & (cnt == 4'd0));
    assign can_accept = (state == IDLE) | fin;
    assign ex_hs      = ex_req_valid & ex_req_ready;
    assign ag_hs      = ag_req_valid & ag_req_ready;
    assign killed     = flush & (op.owner == EX);
    assign ex_done    = fin & (op.owner == EX) & ~flush;
    assign nx_opcode  = ex_hs ? ex_opcode : ag_opcode;
    assign is_mul     = (nx_opcode == MUL_OP) && (MUL_CYCLES > 1);

    alu_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
        .clk          (clk),
        .rst_n        (rst_n),
        .can_accept   (can_accept),
        .flush        (flush),
        .ex_req_valid (ex_req_valid),
        .ag_req_valid (ag_req_valid),
        .ex_req_ready (ex_req_ready),
        .ag_req_ready (ag_req_ready)
    );

    // A handshake always wins; otherwise a MUL keeps counting down unless flushed,
    // and everything else falls back to IDLE with the ALU parked on ZERO_OP.
    always_comb begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
        op_nx    = OP_IDLE;
        if (ex_hs | ag_hs) begin
            op_nx    = ex_hs ? op_t'{opcode: ex_opcode, op1: ex_op1, op2: ex_op2, owner: EX, set_flags: ex_set_flags}
                             : op_t'{opcode: ag_opcode, op1: ag_op1, op2: ag_op2, owner: AG, set_flags: 1'b0};
            state_nx = is_mul ? MULW : EXEC;
            cnt_nx   = is_mul ? 4'(MUL_CYCLES - 1) : 4'd0;
        end else if ((state == MULW) && (cnt != 4'd0) && !killed) begin
            op_nx    = op;
            state_nx = MULW;
            cnt_nx   = cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            op           <= OP_IDLE;
            ex_rsp_valid <= 1'b0;
            ag_rsp_valid <= 1'b0;
            ex_result    <= 32'd0;
            ag_result    <= 32'd0;
            apsr_flags   <= FLAG_RESET;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            op           <= op_nx;
            ex_rsp_valid <= ex_done;
            ag_rsp_valid <= fin & (op.owner == AG);
            ex_result    <= ex_done ? alu_result : ex_result;
            ag_result    <= (fin & (op.owner == AG)) ? alu_result : ag_result;
            apsr_flags   <= (ex_done & op.set_flags) ? alu_flag_q : apsr_flags;
        end
    end

    assign alu_opcode = op.opcode;
    assign alu_op1    = op.op1;
    assign alu_op2    = op.op2;
    assign alu_flag   = apsr_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        ex_req_valid, ex_req_ready, ex_set_flags;
    logic [4:0]  ex_opcode, ag_opcode, alu_opcode;
    logic [31:0] ex_op1, ex_op2, ag_op1, ag_op2, alu_op1, alu_op2, alu_result;
    logic        ag_req_valid, ag_req_ready;
    logic [3:0]  alu_flag, alu_flag_q, apsr_flags;
    logic        ex_rsp_valid, ag_rsp_valid;
    logic [31:0] ex_result, ag_result;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ex_req_valid(ex_req_valid), .ex_req_ready(ex_req_ready), .ex_opcode(ex_opcode),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_set_flags(ex_set_flags),
        .ag_req_valid(ag_req_valid), .ag_req_ready(ag_req_ready), .ag_opcode(ag_opcode),
        .ag_op1(ag_op1), .ag_op2(ag_op2),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_flag(alu_flag),
        .alu_result(alu_result), .alu_flag_q(alu_flag_q),
        .ex_rsp_valid(ex_rsp_valid), .ex_result(ex_result),
        .ag_rsp_valid(ag_rsp_valid), .ag_result(ag_result), .apsr_flags(apsr_flags)
    );

    // Behavioural ALU: returns {NZCV, result}; C on subtract means "no borrow".
    function automatic logic [35:0] alu_model(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        logic [32:0] s;
        logic        v;
        s = 33'd0;
        v = 1'b0;
        if (opc == ADD_OP || opc == ADD_FLAG_OP) begin
            s = {1'b0, a} + {1'b0, b} + ((opc == ADD_FLAG_OP) ? {32'd0, f[1]} : 33'd0);
            v = (a[31] == b[31]) && (s[31] != a[31]);
            return {s[31], s[31:0] == 32'd0, s[32], v, s[31:0]};
        end
        if (opc == SUB_OP1) begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            v = (a[31] != b[31]) && (s[31] != a[31]);
            return {s[31], s[31:0] == 32'd0, s[32], v, s[31:0]};
        end
        if (opc == MUL_OP) begin
            s[31:0] = a * b;
            return {s[31], s[31:0] == 32'd0, f[1:0], s[31:0]};
        end
        return {f, 32'd0};
    endfunction

    assign {alu_flag_q, alu_result} = alu_model(alu_opcode, alu_op1, alu_op2, alu_flag);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_req_valid = 1'b0; ex_opcode = ZERO_OP; ex_op1 = 32'd0; ex_op2 = 32'd0; ex_set_flags = 1'b0;
        ag_req_valid = 1'b0; ag_opcode = ZERO_OP; ag_op1 = 32'd0; ag_op2 = 32'd0; flush = 1'b0;
    endtask

    task automatic drive_ex(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b, input logic sf);
        ex_req_valid = 1'b1; ex_opcode = opc; ex_op1 = a; ex_op2 = b; ex_set_flags = sf;
    endtask

    task automatic drive_ag(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
        ag_req_valid = 1'b1; ag_opcode = opc; ag_op1 = a; ag_op2 = b;
    endtask

    typedef struct {
        logic        is_ag;
        logic [4:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic        sf;
        logic [31:0] exp_res;
        logic [3:0]  exp_apsr;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        if (v.is_ag) drive_ag(v.opc, v.a, v.b);
        else drive_ex(v.opc, v.a, v.b, v.sf);
        #1 check($sformatf("v%0d req_ready", idx), {31'd0, v.is_ag ? ag_req_ready : ex_req_ready}, 32'd1);
        @(negedge clk);
        idle_inputs();
        #1 check($sformatf("v%0d alu_opcode", idx), {27'd0, alu_opcode}, {27'd0, v.opc});
        check($sformatf("v%0d alu_op2", idx), alu_op2, v.b);
        @(negedge clk);
        #1 check($sformatf("v%0d rsp_valid", idx), {31'd0, v.is_ag ? ag_rsp_valid : ex_rsp_valid}, 32'd1);
        check($sformatf("v%0d other_rsp_valid", idx), {31'd0, v.is_ag ? ex_rsp_valid : ag_rsp_valid}, 32'd0);
        check($sformatf("v%0d result", idx), v.is_ag ? ag_result : ex_result, v.exp_res);
        check($sformatf("v%0d apsr", idx), {28'd0, apsr_flags}, {28'd0, v.exp_apsr});
        @(negedge clk);
        #1 check($sformatf("v%0d rsp_pulse_end", idx), {31'd0, ex_rsp_valid | ag_rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, ADD_OP,      32'd5,        32'd7,      1'b1, 32'd12,       4'b0000};
        vecs[1] = '{1'b0, SUB_OP1,     32'd3,        32'd3,      1'b1, 32'd0,        4'b0110};
        vecs[2] = '{1'b0, ADD_OP,      32'hFFFFFFFF, 32'd1,      1'b0, 32'd0,        4'b0110};
        vecs[3] = '{1'b1, ADD_OP,      32'h1000,     32'h20,     1'b0, 32'h1020,     4'b0110};
        vecs[4] = '{1'b0, ADD_OP,      32'h7FFFFFFF, 32'd1,      1'b1, 32'h80000000, 4'b1001};
        vecs[5] = '{1'b0, ADD_FLAG_OP, 32'd1,        32'd1,      1'b1, 32'd2,        4'b0000};
        vecs[6] = '{1'b0, SUB_OP1,     32'd1,        32'd2,      1'b1, 32'hFFFFFFFF, 4'b1000};
        vecs[7] = '{1'b1, SUB_OP1,     32'd10,       32'd4,      1'b0, 32'd6,        4'b1000};
        vecs[8] = '{1'b0, ADD_OP,      32'hFFFFFFFF, 32'd1,      1'b1, 32'd0,        4'b0110};
        vecs[9] = '{1'b0, ADD_FLAG_OP, 32'd1,        32'd1,      1'b1, 32'd3,        4'b0000};

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset alu_opcode", {27'd0, alu_opcode}, {27'd0, ZERO_OP});
        check("reset alu_op1", alu_op1, 32'd0);
        check("reset rsp_valid", {30'd0, ex_rsp_valid, ag_rsp_valid}, 32'd0);
        check("reset ex_result", ex_result, 32'd0);
        check("reset ag_result", ag_result, 32'd0);
        check("reset apsr", {28'd0, apsr_flags}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Back-to-back EX ops: the second sees the flags written by the first.
        @(negedge clk);
        drive_ex(SUB_OP1, 32'd3, 32'd3, 1'b1);
        @(negedge clk);
        drive_ex(ADD_FLAG_OP, 32'd1, 32'd1, 1'b1);
        #1 check("b2b second ready", {31'd0, ex_req_ready}, 32'd1);
        check("b2b first alu_opcode", {27'd0, alu_opcode}, {27'd0, SUB_OP1});
        @(negedge clk);
        idle_inputs();
        #1 check("b2b first rsp_valid", {31'd0, ex_rsp_valid}, 32'd1);
        check("b2b first result", ex_result, 32'd0);
        check("b2b first apsr", {28'd0, apsr_flags}, 32'h6);
        check("b2b second alu_flag", {28'd0, alu_flag}, 32'h6);
        @(negedge clk);
        #1 check("b2b second rsp_valid", {31'd0, ex_rsp_valid}, 32'd1);
        check("b2b second result", ex_result, 32'd3);
        check("b2b second apsr", {28'd0, apsr_flags}, 32'h0);
        repeat (2) @(negedge clk);

        // Both requesters valid continuously: AG wins every fifth cycle.
        drive_ex(ADD_OP, 32'd1, 32'd1, 1'b0);
        drive_ag(ADD_OP, 32'd2, 32'd2);
        for (int i = 0; i < 10; i++) begin
            #1 check($sformatf("starve c%0d ag_ready", i), {31'd0, ag_req_ready}, {31'd0, i % 5 == 4});
            check($sformatf("starve c%0d ex_ready", i), {31'd0, ex_req_ready}, {31'd0, i % 5 != 4});
            @(negedge clk);
        end
        idle_inputs();
        repeat (3) @(negedge clk);

        // AG MUL occupies the ALU for four cycles.
        drive_ag(MUL_OP, 32'd6, 32'd7);
        #1 check("mul hs ready", {31'd0, ag_req_ready}, 32'd1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            idle_inputs();
            #1 check($sformatf("mul c%0d alu_opcode", c), {27'd0, alu_opcode}, {27'd0, MUL_OP});
            check($sformatf("mul c%0d ready", c), {31'd0, ag_req_ready}, {31'd0, c == 4});
            check($sformatf("mul c%0d rsp_valid", c), {31'd0, ag_rsp_valid}, 32'd0);
        end
        @(negedge clk);
        #1 check("mul rsp_valid", {31'd0, ag_rsp_valid}, 32'd1);
        check("mul result", ag_result, 32'd42);
        repeat (2) @(negedge clk);

        // Flush during an EX EXEC cycle, with an AG request taken the same cycle.
        drive_ex(ADD_OP, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        drive_ex(ADD_OP, 32'd9, 32'd9, 1'b1);
        drive_ag(ADD_OP, 32'd2, 32'd3);
        flush = 1'b1;
        #1 check("flush ex_ready", {31'd0, ex_req_ready}, 32'd0);
        check("flush ag_ready", {31'd0, ag_req_ready}, 32'd1);
        @(negedge clk);
        idle_inputs();
        #1 check("flush no ex_rsp", {31'd0, ex_rsp_valid}, 32'd0);
        check("flush apsr kept", {28'd0, apsr_flags}, 32'h0);
        check("flush ag alu_op1", alu_op1, 32'd2);
        @(negedge clk);
        #1 check("flush ag rsp_valid", {31'd0, ag_rsp_valid}, 32'd1);
        check("flush ag result", ag_result, 32'd5);
        check("flush still no ex_rsp", {31'd0, ex_rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);

        // Flush of an EX MUL mid-way parks the ALU and suppresses the response.
        drive_ex(MUL_OP, 32'd2, 32'd3, 1'b1);
        @(negedge clk);
        idle_inputs();
        flush = 1'b1;
        #1 check("mulflush ex_ready", {31'd0, ex_req_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1 check("mulflush alu idle", {27'd0, alu_opcode}, {27'd0, ZERO_OP});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1 check($sformatf("mulflush c%0d no rsp", c), {31'd0, ex_rsp_valid}, 32'd0);
        end

        // Async reset in the middle of a MUL.
        drive_ex(MUL_OP, 32'd3, 32'd4, 1'b1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("midreset alu_opcode", {27'd0, alu_opcode}, {27'd0, ZERO_OP});
        check("midreset alu_op1", alu_op1, 32'd0);
        check("midreset ex_result", ex_result, 32'd0);
        check("midreset ag_result", ag_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1 check($sformatf("midreset c%0d no rsp", c), {31'd0, ex_rsp_valid}, 32'd0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU between two requesters: the execute stage (EX) and the address-generation unit (AG).
- Arbitrates with EX priority plus an AG starvation guard.
- Registers the granted operation and holds it on the ALU for one cycle, or MUL_CYCLES cycles for MUL_OP.
- Returns a registered result to the owning requester.
- Owns the architectural APSR NZCV flag register, which only EX ops with set_flags update.

Parameters:
MUL_CYCLES, 4, cycles MUL_OP occupies the ALU (legal range 1..16).
STARVE_LIMIT, 4, consecutive cycles AG may be denied while valid before it wins once.
FLAG_RESET, 4'b0000, APSR NZCV reset value.

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of in-flight EX op
ex_req_valid  in  1  EX request valid
ex_req_ready  out  1  EX request accepted this cycle
ex_opcode  in  5  ALU opcode (shared cmds encoding)
ex_op1, ex_op2  in  32  operands
ex_set_flags  in  1  update APSR on completion
ag_req_valid  in  1  AG request valid
ag_req_ready  out  1  AG request accepted this cycle
ag_opcode  in  5  ALU opcode
ag_op1, ag_op2  in  32  operands
alu_opcode  out  5  to ALU opcode
alu_op1, alu_op2  out  32  to ALU operands
alu_flag  out  4  to ALU flag input; always equals apsr_flags
alu_result  in  32  from ALU result
alu_flag_q  in  4  from ALU flag_q
ex_rsp_valid  out  1  one-cycle pulse, EX result valid
ex_result  out  32  EX result
ag_rsp_valid  out  1  one-cycle pulse, AG result valid
ag_result  out  32  AG result
apsr_flags  out  4  NZCV

Behaviour:
Interface: one clock, clk; reset rst_n is asynchronous, active-low.

Reset values:
- State IDLE.
- All *_rsp_valid = 0, results = 0.
- apsr_flags = FLAG_RESET.
- alu_opcode = ZERO_OP, alu_op1/op2 = 0.
- Starvation counter = 0, owner = NONE.
- Reset mid-operation discards the op: no response, no flag write.

States:
- IDLE: ALU driven with ZERO_OP and zero operands.
- EXEC: single-cycle op.
- MULW: MUL_OP, down-counter cnt.

Acceptance window:
- can_accept = IDLE, or EXEC, or (MULW and cnt==0). This gives back-to-back single-cycle throughput.
- ex_req_ready = can_accept & ~flush & ~(ag_req_valid & starve_hit).
- ag_req_ready = can_accept & (~ex_req_valid | flush | starve_hit).
- Ready never depends on the requester's own valid.
- Handshake = valid & ready.

On handshake:
- Latch opcode, operands, owner and set_flags into the op register.
- Next state is EXEC, or MULW with cnt = MUL_CYCLES-1.
- If MUL_CYCLES==1, MUL_OP goes to EXEC.

Starvation guard:
- starve_hit = (starve_cnt == STARVE_LIMIT).
- starve_cnt increments, saturating, when ag_req_valid & ~ag_req_ready.
- starve_cnt clears on an AG handshake or when ag_req_valid is low.

Latency:
- Handshake at cycle T.
- ALU driven from the op register in T+1 (through T+MUL_CYCLES for MUL).
- Result and flags sampled at the end of the final execution cycle.
- *_rsp_valid high for exactly one cycle after that: T+2 for single-cycle ops, T+1+MUL_CYCLES for MUL.
- No response backpressure.
- Final cycle with no new handshake returns the block to IDLE.

Flags:
- At the end of the final cycle, apsr_flags <= alu_flag_q, only if owner==EX & set_flags & ~flush.
- A following op's execution cycle sees the updated APSR, so there is no hazard.

Flush:
- If owner==EX in EXEC/MULW, the op is dropped: no ex_rsp_valid, no APSR write, next state IDLE unless AG handshakes this cycle.
- If owner==AG, the op continues unaffected.
- During a flush cycle EX cannot be accepted.

Simultaneous flush with EX final cycle: flush wins; no response, no flag update.

Width rules: results are 32 bits and taken verbatim from alu_result; the block performs no arithmetic of its own.

Decomposition:
- Package alu_arb_pkg: state enum {IDLE, EXEC, MULW}, owner enum {NONE, EX, AG}, op-register struct (opcode, op1, op2, owner, set_flags).
- Opcode constants (ZERO_OP, MUL_OP) come from the shared cmds definitions.
- One sub-module: alu_arb_grant, containing the ready/grant logic and the starvation counter.

Test Plan:
1. EX ADD_OP 5+7, set_flags=1 at T -> alu_opcode=ADD_OP in T+1; ex_rsp_valid at T+2 with ex_result=12; apsr_flags=0000 from T+2.
2. EX SUB_OP1 3-3, set_flags=1, back-to-back with EX ADD_FLAG_OP 1+1 -> first result 0, apsr Z=1,C=1; second op sees alu_flag=0110, result=3.
3. EX and AG both valid continuously -> EX granted 4 cycles, AG granted on the 5th (ag_req_ready=1, ex_req_ready=0), counter cleared; pattern repeats.
4. AG MUL_OP 6*7 with MUL_CYCLES=4 -> ALU held for 4 cycles; ag_rsp_valid 5 cycles after handshake with 42; ready low for cycles 1-3.
5. EX ADD_OP with set_flags, flush asserted in its EXEC cycle -> no ex_rsp_valid, apsr unchanged; concurrent AG request accepted the same cycle.
6. rst_n low mid-MULW -> all outputs at reset values immediately; no response after release.
